// File: rtl/masked_xor_fold_if.sv
// -----------------------------------------------------------------------------
// masked_xor_fold_if
//
// Purpose: bundles the data/handshake signals of the masked_xor_fold unmasking
// unit. The clock and the reset stay plain ports on the module.
//
// Parameters:
//   K_WIDTH   bit width of one share
//   N_SHARES  number of input shares (>= 2)
//
// Signals (names as seen by the unit):
//   i_dvld  input shares valid
//   i_rvld  randomness on i_n valid this cycle
//   i_n     N_SHARES-1 fresh random words, word r at [r*K_WIDTH +: K_WIDTH]
//   i_x     input shares, share s at [s*K_WIDTH +: K_WIDTH]
//   i_ordy  downstream ready
//   o_irdy  upstream ready; an input is taken when i_dvld & o_irdy
//   o_z     recombined cleartext
//   o_dvld  o_z valid
//
// Modports:
//   master  the producer/consumer side that drives i_* and observes o_*
//   slave   the unmasking unit itself
// -----------------------------------------------------------------------------
interface masked_xor_fold_if #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3
);
  localparam int RANDNUM = N_SHARES - 1;

  logic                          i_dvld;
  logic                          i_rvld;
  logic [K_WIDTH*RANDNUM-1:0]    i_n;
  logic [K_WIDTH*N_SHARES-1:0]   i_x;
  logic                          i_ordy;
  logic                          o_irdy;
  logic [K_WIDTH-1:0]            o_z;
  logic                          o_dvld;

  modport master (
    output i_dvld,
    output i_rvld,
    output i_n,
    output i_x,
    output i_ordy,
    input  o_irdy,
    input  o_z,
    input  o_dvld
  );

  modport slave (
    input  i_dvld,
    input  i_rvld,
    input  i_n,
    input  i_x,
    input  i_ordy,
    output o_irdy,
    output o_z,
    output o_dvld
  );
endinterface

// File: rtl/masked_xor_fold.sv
// -----------------------------------------------------------------------------
// masked_xor_fold
//
// Purpose: N-share Boolean unmasking. Recombines N_SHARES shares of a K_WIDTH
// value into the cleartext XOR through a registered refresh-before-fold tree.
// Every pair of shares is re-masked with one fresh random word and registered
// before the pair is XORed together in the next layer, so no register ever
// holds a partially unmasked value that has not been refreshed first.
//
// Parameters:
//   K_WIDTH   bit width of one share (default 32)
//   N_SHARES  number of input shares, >= 2 (default 3)
//   Derived (localparams, not overridable):
//     LAYERS  = $clog2(N_SHARES)  pipeline depth
//     RANDNUM = N_SHARES - 1      random words consumed per advance
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset; clears all valid and data registers
//   bus     masked_xor_fold_if.slave (i_dvld, i_rvld, i_n, i_x, i_ordy,
//           o_irdy, o_z, o_dvld)
//
// Optional build macro:
//   MASKED_XOR_FOLD_ZEROIZE_EN  when defined, a stage whose incoming valid is 0
//                               loads zeros on an advance instead of folded
//                               share data, so idle registers hold no share
//                               remnants and o_z reads 0 behind a bubble.
// -----------------------------------------------------------------------------
module masked_xor_fold #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  masked_xor_fold_if.slave bus
);

  localparam int LAYERS  = $clog2(N_SHARES);
  localparam int RANDNUM = N_SHARES - 1;

  // Number of shares entering layer l: m_0 = N_SHARES, m_{l+1} = ceil(m_l/2).
  function automatic int layer_m(input int l);
    int m;
    m = N_SHARES;
    for (int i = 0; i < l; i++) begin
      m = (m + 1) / 2;
    end
    return m;
  endfunction

  if (N_SHARES < 2) begin : g_bad_param
    $error("masked_xor_fold: N_SHARES must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Storage. Every layer gets a full N_SHARES-wide row for regular indexing;
  // entries at or above m_l are tied to zero and never observed.
  // ---------------------------------------------------------------------------
  logic [K_WIDTH-1:0] sh_q    [LAYERS][N_SHARES];  // stage registers
  logic [K_WIDTH-1:0] sh_d    [LAYERS][N_SHARES];  // value loaded on advance
  logic [K_WIDTH-1:0] lay_in  [LAYERS][N_SHARES];  // shares entering layer l
  logic [K_WIDTH-1:0] lay_ref [LAYERS][N_SHARES];  // shares after refresh
  logic [LAYERS-1:0]  v_q;                         // per-stage valid
  logic [LAYERS-1:0]  v_d;                         // valid arriving at stage
  logic               en;                          // global advance

  // The whole pipe moves as one: it needs fresh randomness every advance and
  // may only move while the output is empty or being consumed.
  assign en = bus.i_rvld & (~v_q[LAYERS-1] | bus.i_ordy);

  // ---------------------------------------------------------------------------
  // Per-layer combinational datapath
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
    localparam int M    = layer_m(gi);
    // First random word of this layer: earlier layers used N_SHARES - M words.
    localparam int ROFF = N_SHARES - M;

    if (gi == 0) begin : g_vin_first
      assign v_d[gi] = bus.i_dvld;
    end else begin : g_vin_next
      assign v_d[gi] = v_q[gi-1];
    end

    for (genvar gj = 0; gj < N_SHARES; gj++) begin : g_share
      if (gj >= M) begin : g_idle
        assign lay_in[gi][gj]  = '0;
        assign lay_ref[gi][gj] = '0;
        assign sh_d[gi][gj]    = '0;
      end else begin : g_live
        // -- share source -----------------------------------------------------
        if (gi == 0) begin : g_src_x
          assign lay_in[gi][gj] = bus.i_x[gj*K_WIDTH +: K_WIDTH];
        end else if (2*gj + 1 < layer_m(gi - 1)) begin : g_src_fold
          // Fold a refreshed, registered pair from the previous stage.
          assign lay_in[gi][gj] = sh_q[gi-1][2*gj] ^ sh_q[gi-1][2*gj+1];
        end else begin : g_src_fwd
          // Odd last share of the previous stage is forwarded unchanged.
          assign lay_in[gi][gj] = sh_q[gi-1][2*gj];
        end

        // -- refresh ----------------------------------------------------------
        // Both members of pair gj/2 get the same random word, so their XOR is
        // preserved while each individual register value is re-masked.
        if ((gj / 2) < (M / 2)) begin : g_refresh
          assign lay_ref[gi][gj] =
            lay_in[gi][gj] ^ bus.i_n[(ROFF + gj/2)*K_WIDTH +: K_WIDTH];
        end else begin : g_pass
          assign lay_ref[gi][gj] = lay_in[gi][gj];
        end

        // -- stage load value ---------------------------------------------------
`ifdef MASKED_XOR_FOLD_ZEROIZE_EN
        assign sh_d[gi][gj] = v_d[gi] ? lay_ref[gi][gj] : '0;
`else
        assign sh_d[gi][gj] = lay_ref[gi][gj];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers: all stages shift together on en, hold otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q  <= '0;
      sh_q <= '{default: '0};
    end else if (en) begin
      v_q  <= v_d;
      sh_q <= sh_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The last stage always holds exactly two shares; their XOR is the
  // cleartext and is produced combinationally from the registers.
  // ---------------------------------------------------------------------------
  assign bus.o_irdy = en;
  assign bus.o_dvld = v_q[LAYERS-1];
  assign bus.o_z    = sh_q[LAYERS-1][0] ^ sh_q[LAYERS-1][1];

endmodule

// File: tb/tb_masked_xor_fold.sv
// -----------------------------------------------------------------------------
// tb_masked_xor_fold
//
// Two instances: A (N=3, K=32) for the wide single-vector case, B (N=5, K=8)
// for streaming, backpressure, randomness stalls and asynchronous reset.
// Expected cleartexts are hand-computed constants in exp_tab.
// -----------------------------------------------------------------------------
module tb_masked_xor_fold;

  localparam int N_ITEMS = 10;

  logic clk_i;
  logic rst_ni;

  int n_checks;
  int n_fail;
  int acc_idx;   // next B item to offer / number accepted
  int out_idx;   // next B item expected at the output

  logic [7:0] shares_tab [N_ITEMS][5];
  logic [7:0] exp_tab    [N_ITEMS];

  masked_xor_fold_if #(.K_WIDTH(32), .N_SHARES(3)) bus_a ();
  masked_xor_fold_if #(.K_WIDTH(8),  .N_SHARES(5)) bus_b ();

  masked_xor_fold #(.K_WIDTH(32), .N_SHARES(3)) u_dut_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_a)
  );

  masked_xor_fold #(.K_WIDTH(8), .N_SHARES(5)) u_dut_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_b)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer the next B item (or a bubble) together with fresh randomness.
  task automatic drive_b(input bit dv);
    bus_b.i_n = $urandom;
    if (dv && acc_idx < N_ITEMS) begin
      for (int s = 0; s < 5; s++) begin
        bus_b.i_x[s*8 +: 8] = shares_tab[acc_idx][s];
      end
      bus_b.i_dvld = 1'b1;
    end else begin
      bus_b.i_dvld = 1'b0;
    end
  endtask

  // Check any output consumed at the coming edge, note any acceptance,
  // then advance one clock.
  task automatic cycle_b();
    #1;
    if (bus_b.o_dvld && bus_b.i_ordy && bus_b.i_rvld) begin
      if (out_idx < acc_idx) begin
        $display("[b] out item %0d z=0x%02h", out_idx, bus_b.o_z);
        check_eq("b_out_z", 32'(bus_b.o_z), 32'(exp_tab[out_idx]));
      end else begin
        check_eq("b_extra_out", 32'(bus_b.o_dvld), 32'd0);
      end
      out_idx++;
    end
    if (bus_b.i_dvld && bus_b.o_irdy) begin
      $display("[b] in  item %0d accepted", acc_idx);
      acc_idx++;
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    acc_idx  = 0;
    out_idx  = 0;

    shares_tab = '{
      '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10},
      '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h11, 8'h22, 8'h44, 8'h88, 8'h01},
      '{8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h3C},
      '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08},
      '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A},
      '{8'h01, 8'h01, 8'h02, 8'h02, 8'h7E},
      '{8'hC3, 8'h3C, 8'h00, 8'hFF, 8'h01}
    };
    exp_tab = '{8'h1F, 8'hFF, 8'hFE, 8'h3C, 8'hF8,
                8'h92, 8'h00, 8'h5A, 8'h7E, 8'h01};

    // ---------------- reset ----------------
    rst_ni       = 1'b0;
    bus_a.i_dvld = 1'b0; bus_a.i_rvld = 1'b0; bus_a.i_ordy = 1'b0;
    bus_a.i_n    = '0;   bus_a.i_x    = '0;
    bus_b.i_dvld = 1'b0; bus_b.i_rvld = 1'b0; bus_b.i_ordy = 1'b0;
    bus_b.i_n    = '0;   bus_b.i_x    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_a_dvld", 32'(bus_a.o_dvld), 32'd0);
    check_eq("rst_a_z",    32'(bus_a.o_z),    32'd0);
    check_eq("rst_b_dvld", 32'(bus_b.o_dvld), 32'd0);
    check_eq("rst_b_z",    32'(bus_b.o_z),    32'd0);
    rst_ni = 1'b1;
    bus_b.i_rvld = 1'b1;
    #1 check_eq("irdy_follows_rvld_hi", 32'(bus_b.o_irdy), 32'd1);
    bus_b.i_rvld = 1'b0;
    #1 check_eq("irdy_follows_rvld_lo", 32'(bus_b.o_irdy), 32'd0);
    step();

    // ---------------- A: N=3, K=32 single vector ----------------
    bus_a.i_rvld = 1'b1;
    bus_a.i_ordy = 1'b1;
    bus_a.i_x    = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678};
    bus_a.i_n    = {$urandom, $urandom};
    bus_a.i_dvld = 1'b1;
    #1 check_eq("a_irdy", 32'(bus_a.o_irdy), 32'd1);
    step();
    bus_a.i_dvld = 1'b0;
    bus_a.i_x    = '0;
    bus_a.i_n    = {$urandom, $urandom};
    #1 check_eq("a_lat_cycle1_dvld", 32'(bus_a.o_dvld), 32'd0);
    step();
    bus_a.i_n = {$urandom, $urandom};
    #1;
    check_eq("a_lat_cycle2_dvld", 32'(bus_a.o_dvld), 32'd1);
    check_eq("a_z", bus_a.o_z, 32'hB89EFCD2);
    $display("[a] out z=0x%08h", bus_a.o_z);
    step();
    bus_a.i_n = {$urandom, $urandom};
    #1 check_eq("a_bubble_dvld", 32'(bus_a.o_dvld), 32'd0);
    step();

    // ---------------- B: back-to-back, latency 3 ----------------
    bus_b.i_rvld = 1'b1;
    bus_b.i_ordy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_b(1'b1);
      #1 check_eq("b_lat_dvld", 32'(bus_b.o_dvld), 32'(c >= 3));
      cycle_b();
    end

    // ---------------- B: downstream backpressure ----------------
    bus_b.i_ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive_b(1'b1);
      #1;
      check_eq("b_ordy_stall_irdy", 32'(bus_b.o_irdy), 32'd0);
      check_eq("b_ordy_stall_dvld", 32'(bus_b.o_dvld), 32'd1);
      check_eq("b_ordy_stall_z",    32'(bus_b.o_z),    32'(exp_tab[out_idx]));
      cycle_b();
    end
    bus_b.i_ordy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_b(1'b1);
      cycle_b();
    end

    // ---------------- B: randomness stall ----------------
    bus_b.i_rvld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_b(1'b1);
      #1;
      check_eq("b_rvld_stall_irdy", 32'(bus_b.o_irdy), 32'd0);
      check_eq("b_rvld_stall_dvld", 32'(bus_b.o_dvld), 32'd1);
      check_eq("b_rvld_stall_z",    32'(bus_b.o_z),    32'(exp_tab[out_idx]));
      cycle_b();
    end
    bus_b.i_rvld = 1'b1;

    // ---------------- B: drain ----------------
    for (int k = 0; k < 12 && out_idx < acc_idx; k++) begin
      drive_b(1'b0);
      cycle_b();
    end
    check_eq("b_drain_count", 32'(out_idx), 32'(acc_idx));
    for (int k = 0; k < 3; k++) begin
      drive_b(1'b0);
      cycle_b();
    end
    check_eq("b_idle_dvld", 32'(bus_b.o_dvld), 32'd0);
`ifdef MASKED_XOR_FOLD_ZEROIZE_EN
    check_eq("b_zeroize_z", 32'(bus_b.o_z), 32'd0);
    check_eq("a_zeroize_z", bus_a.o_z,      32'd0);
`endif

    // ---------------- B: asynchronous reset with items in flight -------------
    drive_b(1'b1);
    cycle_b();
    drive_b(1'b1);
    cycle_b();
    drive_b(1'b0);
    bus_b.i_ordy = 1'b0;
    cycle_b();
    #1;
    check_eq("b_pre_rst_dvld", 32'(bus_b.o_dvld), 32'd1);
    check_eq("b_pre_rst_z",    32'(bus_b.o_z),    32'(exp_tab[8]));
    #2 rst_ni = 1'b0;
    #1;
    check_eq("b_async_rst_dvld", 32'(bus_b.o_dvld), 32'd0);
    check_eq("b_async_rst_z",    32'(bus_b.o_z),    32'd0);
    step();
    step();
    rst_ni       = 1'b1;
    out_idx      = acc_idx;
    bus_b.i_ordy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_b(1'b0);
      #1 check_eq("b_no_stale_dvld", 32'(bus_b.o_dvld), 32'd0);
      cycle_b();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
